// File: rtl/param_shift_reg.sv
// ---------------------------------------------------------------------------
// param_shift_reg
//
// Parameterised shift register with parallel load, serial shift, lossless
// rotate, a saturating count of shifts/rotates since the last load, and a
// one-cycle completion pulse when that count first reaches WIDTH.
//
// Parameters
//   WIDTH      register width in bits (2..32)
//   MSB_FIRST  1: shift toward MSB, serial out from bit WIDTH-1
//              0: shift toward LSB, serial out from bit 0
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   enable     clock enable, low holds q and bit_cnt
//   mode       00 hold, 01 shift, 10 parallel load, 11 rotate
//   sin        serial input, used only in shift mode
//   load_data  parallel load value
//   q          registered register contents
//   sout       serial output, taken combinationally from q
//   bit_cnt    shifts/rotates since the last load, saturates at WIDTH
//   full       high while bit_cnt equals WIDTH
//   done       one-cycle pulse after the edge where bit_cnt reaches WIDTH
// ---------------------------------------------------------------------------
module param_shift_reg #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   localparam int CW       = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             sin,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic [CW-1:0]    bit_cnt,
   output logic             full,
   output logic             done
);

   localparam logic [1:0]    MODE_HOLD   = 2'b00;
   localparam logic [1:0]    MODE_SHIFT  = 2'b01;
   localparam logic [1:0]    MODE_LOAD   = 2'b10;
   localparam logic [1:0]    MODE_ROTATE = 2'b11;

   localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [WIDTH-1:0] q_q,       q_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             done_q,    done_d;
   logic             in_bit_s;

   // Move the register one place in the configured direction, inserting in_bit.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic             in_bit);
      logic [WIDTH-1:0] res;
      if (MSB_FIRST != 0) begin
         res = {cur[WIDTH-2:0], in_bit};
      end else begin
         res = {in_bit, cur[WIDTH-1:1]};
      end
      return res;
   endfunction

   // Serial output is the bit that leaves on the next shift.
   assign sout = (MSB_FIRST != 0) ? q_q[WIDTH-1] : q_q[0];

   // Rotate feeds back the outgoing bit so sin is never looked at outside shift mode.
   assign in_bit_s = (mode == MODE_ROTATE) ? sout : sin;

   // Next-state decode: enable gates everything, then mode selects the operation.
   always_comb begin
      q_d       = q_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      if (!enable) begin
         done_d = 1'b0;
      end else begin
         case (mode)
            MODE_SHIFT, MODE_ROTATE: begin
               q_d = shift_in(q_q, in_bit_s);
               // Count saturates so extra shifts never re-trigger done.
               if (bit_cnt_q != CNT_MAX) begin
                  bit_cnt_d = bit_cnt_q + CNT_ONE;
               end else begin
                  bit_cnt_d = bit_cnt_q;
               end
               done_d = (bit_cnt_q == CNT_LAST);
            end
            MODE_LOAD: begin
               q_d       = load_data;
               bit_cnt_d = '0;
               done_d    = 1'b0;
            end
            MODE_HOLD: begin
               done_d = 1'b0;
            end
            default: begin
               done_d = 1'b0;
            end
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q       <= '0;
         bit_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         q_q       <= q_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
      end
   end

   assign q       = q_q;
   assign bit_cnt = bit_cnt_q;
   assign full    = (bit_cnt_q == CNT_MAX);
   assign done    = done_q;

endmodule

// File: tb/tb_param_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_param_shift_reg
//
// Three instances share one stimulus stream: 8-bit MSB-first, 8-bit
// LSB-first and 5-bit MSB-first. A behavioural model (integer arithmetic on
// the register value and a saturating count) predicts every output and is
// compared on each falling edge. Directed sequences with hand-computed
// literal results pin the model, then randomized stimulus follows.
// ---------------------------------------------------------------------------
module tb_param_shift_reg;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [1:0] mode;
   logic       sin;
   logic [7:0] load_data;

   logic [7:0] q0, q1;
   logic [4:0] q2;
   logic       sout0, sout1, sout2;
   logic [3:0] bc0, bc1;
   logic [2:0] bc2;
   logic       full0, full1, full2;
   logic       done0, done1, done2;

   int errors = 0;
   int checks = 0;

   param_shift_reg #(.WIDTH(8), .MSB_FIRST(1)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sin(sin),
      .load_data(load_data), .q(q0), .sout(sout0), .bit_cnt(bc0),
      .full(full0), .done(done0));

   param_shift_reg #(.WIDTH(8), .MSB_FIRST(0)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sin(sin),
      .load_data(load_data), .q(q1), .sout(sout1), .bit_cnt(bc1),
      .full(full1), .done(done1));

   param_shift_reg #(.WIDTH(5), .MSB_FIRST(1)) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sin(sin),
      .load_data(load_data[4:0]), .q(q2), .sout(sout2), .bit_cnt(bc2),
      .full(full2), .done(done2));

   always #5 clk = ~clk;

   // Actual outputs gathered per instance for the compare loop.
   logic [31:0] aq[3], as_[3], ac[3], af[3], ad[3];
   assign aq[0] = 32'(q0);    assign aq[1] = 32'(q1);    assign aq[2] = 32'(q2);
   assign as_[0] = 32'(sout0); assign as_[1] = 32'(sout1); assign as_[2] = 32'(sout2);
   assign ac[0] = 32'(bc0);   assign ac[1] = 32'(bc1);   assign ac[2] = 32'(bc2);
   assign af[0] = 32'(full0); assign af[1] = 32'(full1); assign af[2] = 32'(full2);
   assign ad[0] = 32'(done0); assign ad[1] = 32'(done1); assign ad[2] = 32'(done2);

   // Model configuration and state.
   int mw[3]   = '{8, 8, 5};
   int mmsb[3] = '{1, 0, 1};
   int mq[3];
   int mc[3];
   int md[3];
   int w_m, mask_m, out_m, in_m;

   task automatic chk(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, k, $time, act, exp);
      end
   endtask

   // Behavioural model: register value as an integer, count saturating at width.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         w_m    = mw[k];
         mask_m = (1 << w_m) - 1;
         if (reset) begin
            mq[k] = 0; mc[k] = 0; md[k] = 0;
         end else if (!enable) begin
            md[k] = 0;
         end else if (mode == 2'd2) begin
            mq[k] = int'(load_data) & mask_m; mc[k] = 0; md[k] = 0;
         end else if (mode == 2'd1 || mode == 2'd3) begin
            out_m = (mmsb[k] != 0) ? ((mq[k] >> (w_m - 1)) & 1) : (mq[k] & 1);
            in_m  = (mode == 2'd3) ? out_m : ((sin === 1'b1) ? 1 : 0);
            if (mmsb[k] != 0) mq[k] = ((mq[k] << 1) | in_m) & mask_m;
            else              mq[k] = (mq[k] >> 1) | (in_m << (w_m - 1));
            md[k] = (mc[k] == w_m - 1) ? 1 : 0;
            if (mc[k] < w_m) mc[k] = mc[k] + 1;
         end else begin
            md[k] = 0;
         end
      end
   end

   // Per-cycle compare of every instance against the model.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk("q", k, aq[k], 32'(mq[k]));
         chk("sout", k, as_[k],
             32'((mmsb[k] != 0) ? ((mq[k] >> (mw[k] - 1)) & 1) : (mq[k] & 1)));
         chk("bit_cnt", k, ac[k], 32'(mc[k]));
         chk("full", k, af[k], 32'((mc[k] == mw[k]) ? 1 : 0));
         chk("done", k, ad[k], 32'(md[k]));
      end
   end

   task automatic step(input logic r, input logic e, input logic [1:0] m,
                       input logic s, input logic [7:0] ld);
      reset = r; enable = e; mode = m; sin = s; load_data = ld;
      @(negedge clk);
   endtask

   logic [7:0] seq;
   int dcnt;

   initial begin
      reset = 1'b1; enable = 1'b0; mode = 2'b00; sin = 1'b0; load_data = 8'h00;
      @(negedge clk);
      chk("reset_q", 0, 32'(q0), 32'h0);
      chk("reset_cnt", 0, 32'(bc0), 32'h0);

      // Load 0xA5, shift out MSB-first with zeros in.
      step(1'b0, 1'b1, 2'b10, 1'b0, 8'hA5);
      seq = 8'b1010_0101; dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         chk("a5_sout", 0, 32'(sout0), 32'(seq[7-i]));
         step(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
         dcnt += int'(done0);
      end
      chk("a5_done_last", 0, 32'(done0), 32'h1);
      chk("a5_q", 0, 32'(q0), 32'h00);
      chk("a5_full", 0, 32'(full0), 32'h1);
      chk("a5_done_count", 0, 32'(dcnt), 32'h1);

      // Load zero, shift in 1,1,0,1,0,0,1,0.
      step(1'b0, 1'b1, 2'b10, 1'b0, 8'h00);
      seq = 8'b1101_0010; dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 2'b01, seq[7-i], 8'h00);
         dcnt += int'(done0);
      end
      chk("d2_q", 0, 32'(q0), 32'hD2);
      chk("d2_cnt", 0, 32'(bc0), 32'h8);
      chk("d2_done_count", 0, 32'(dcnt), 32'h1);

      // LSB-first rotate of 0x81 with sin undriven.
      step(1'b0, 1'b1, 2'b10, 1'bx, 8'h81);
      seq = 8'b1000_0001; dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         chk("rot_sout", 1, 32'(sout1), 32'(seq[7-i]));
         step(1'b0, 1'b1, 2'b11, 1'bx, 8'h00);
         dcnt += int'(done1);
      end
      chk("rot_q", 1, 32'(q1), 32'h81);
      chk("rot_done_count", 1, 32'(dcnt), 32'h1);

      // Load 0x3C, 3 shifts, 4 disabled cycles, 5 more shifts.
      step(1'b0, 1'b1, 2'b10, 1'b0, 8'h3C);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 2'b01, 1'b1, 8'hFF);
         chk("frz_cnt", 0, 32'(bc0), 32'h3);
         chk("frz_q", 0, 32'(q0), 32'hE0);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
         chk("frz_done", 0, 32'(done0), 32'((i == 4) ? 1 : 0));
      end

      // Shifts past saturation, then reload.
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
         chk("sat_cnt", 0, 32'(bc0), 32'h8);
         chk("sat_done", 0, 32'(done0), 32'h0);
         chk("sat_full", 0, 32'(full0), 32'h1);
      end
      chk("sat_q", 0, 32'(q0), 32'h03);
      step(1'b0, 1'b1, 2'b10, 1'b0, 8'h5A);
      chk("reload_cnt", 0, 32'(bc0), 32'h0);
      chk("reload_full", 0, 32'(full0), 32'h0);

      // Reset mid-sequence while shifting.
      step(1'b0, 1'b1, 2'b10, 1'b0, 8'hFF);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
      step(1'b1, 1'b1, 2'b01, 1'b1, 8'h00);
      chk("rst_q", 0, 32'(q0), 32'h00);
      chk("rst_cnt", 0, 32'(bc0), 32'h0);
      chk("rst_done", 0, 32'(done0), 32'h0);
      chk("rst_sout", 0, 32'(sout0), 32'h0);
      step(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
      chk("post_rst_cnt", 0, 32'(bc0), 32'h1);

      // Randomized traffic, weighted toward shift and rotate.
      for (int i = 0; i < 600; i++) begin
         logic [1:0] m;
         int pick;
         pick = int'($urandom_range(0, 9));
         m = (pick < 5) ? 2'b01 : (pick < 7) ? 2'b11 : (pick < 8) ? 2'b10 : 2'b00;
         step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
              m, 1'($urandom), 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
